// File: rtl/sram_data_controller_if.sv
// MEM-stage data-memory request/response bundle between the pipeline and the
// SRAM data controller.
interface sram_data_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  // Pipeline MEM stage issues requests and freezes on !ready.
  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  // Controller answers requests and reports completion.
  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_data_controller.sv
// Serves 32-bit MEM-stage loads/stores from a 16-bit asynchronous SRAM as two
// half-word accesses, each held for WAIT_CYCLES cycles (legal range 1..15;
// writes need at least 2 so WE_N can rise while data is still driven).
module sram_data_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_data_controller_if.slave mem,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  inout  wire  [15:0]          SRAM_DQ,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_WE_N
);

  localparam int unsigned WW       = SRAM_AW - 1;           // word address width
  localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);   // final cycle of a phase

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [WW-1:0] word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   offset;
  logic [WW-1:0] word_addr;
  logic          unused_addr_bits;

  logic          dq_oe;
  logic [15:0]   dq_out;

  // Word index inside the SRAM; low byte-offset bits and bits above the SRAM
  // size are dropped, so addresses wrap modulo the SRAM capacity.
  assign offset           = mem.address - BASE_ADDR;
  assign word_addr        = offset[SRAM_AW:2];
  assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // State register: every flop clears on reset so an abandoned access leaves
  // no partial result behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: request capture, per-phase wait counting, read capture.
  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (mem.rd_en || mem.wr_en) begin
          state_d = S_LOW;
          cnt_d   = '0;
          word_d  = word_addr;
          wdata_d = mem.write_data;
          is_wr_d = mem.wr_en;  // write wins when both are requested
        end
      end
      S_LOW: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      // One cycle for the pipeline to advance; a request still visible here
      // belongs to the access just finished and is not restarted.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: SRAM strobes, address and data drive derived from state.
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    dq_out    = wdata_q[15:0];

    if (state_q == S_LOW || state_q == S_HIGH) begin
      SRAM_CE_N = 1'b0;
      SRAM_ADDR = {word_q, state_q == S_HIGH};
      if (state_q == S_HIGH) dq_out = wdata_q[31:16];
      if (is_wr_q) begin
        // WE_N rises for the last cycle of the phase while data stays driven,
        // giving the SRAM hold time past the write edge.
        dq_oe     = 1'b1;
        SRAM_WE_N = (cnt_q == LAST_CNT);
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign SRAM_DQ       = dq_oe ? dq_out : 16'hzzzz;
  assign mem.read_data = rdata_q;
  assign mem.ready     = ((state_q == S_IDLE) && !mem.rd_en && !mem.wr_en)
                       || (state_q == S_DONE);

endmodule

// File: tb/tb_sram_data_controller.sv
// Bench for sram_data_controller: directed vector table, hand sequences for
// back-to-back, reset-abort and WAIT_CYCLES=4 cases, then randomized accesses
// checked against a word-level memory model.
module tb_sram_data_controller;

  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;
  localparam int unsigned WAIT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  sram_data_controller_if m2 ();
  sram_data_controller_if m4 ();

  wire  [15:0]   dq2, dq4;
  logic [AW-1:0] addr2, addr4;
  logic          ce2, oe2, we2, ce4, oe4, we4;

  sram_data_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT), .SRAM_AW(AW)) u_dut2 (
    .clk(clk), .rst(rst), .mem(m2.slave),
    .SRAM_ADDR(addr2), .SRAM_DQ(dq2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2), .SRAM_WE_N(we2)
  );

  sram_data_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(4), .SRAM_AW(AW)) u_dut4 (
    .clk(clk), .rst(rst), .mem(m4.slave),
    .SRAM_ADDR(addr4), .SRAM_DQ(dq4), .SRAM_CE_N(ce4), .SRAM_OE_N(oe4), .SRAM_WE_N(we4)
  );

  // Asynchronous SRAM models: read drive while selected with OE low; a write
  // lands when WE rises with chip enable still asserted.
  bit [15:0] sram2 [0:(1<<AW)-1];
  bit [15:0] sram4 [0:(1<<AW)-1];
  bit        prev_we2_low, prev_we4_low;

  assign dq2 = (!ce2 && !oe2 && we2) ? sram2[addr2] : 16'hzzzz;
  assign dq4 = (!ce4 && !oe4 && we4) ? sram4[addr4] : 16'hzzzz;

  always @(negedge clk) begin
    if (!ce2 && we2 && prev_we2_low) sram2[addr2] <= dq2;
    prev_we2_low <= !ce2 && !we2;
    if (!ce4 && we4 && prev_we4_low) sram4[addr4] <= dq4;
    prev_we4_low <= !ce4 && !we4;
  end

  // Word-level reference: memory indexed by word, plus the last load result.
  bit [31:0] ref_mem [int];
  bit [31:0] ref_rd;

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'h1_FFFF);
  endfunction

  function automatic bit [31:0] ref_read(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Runs one access on the WAIT=2 controller starting at a negedge; returns at
  // the negedge inside DONE with the cycle counts seen while ready was low.
  task automatic access2(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, output int lows,
                         output int we_lo, output int we_hi, output logic [31:0] rdv);
    bit done;
    m2.rd_en      = rd;
    m2.wr_en      = wr;
    m2.address    = a;
    m2.write_data = wd;
    lows  = 0;
    we_lo = 0;
    we_hi = 0;
    done  = 1'b0;
    #1;
    if (m2.ready) @(negedge clk);  // previous access still in DONE
    check("idle_cycle_before_accept", {30'h0, m2.ready, ce2}, 32'h1);
    lows = 1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (m2.ready) done = 1'b1;
      else begin
        lows++;
        if (!we2) begin
          if (addr2[0]) we_hi++;
          else          we_lo++;
        end
      end
    end
    if (!done) check("access2_timeout", 32'h0, 32'h1);
    rdv = m2.read_data;
  endtask

  task automatic idle2();
    m2.rd_en = 1'b0;
    m2.wr_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic access4(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, output int lows, output logic [31:0] rdv);
    bit done;
    m4.rd_en      = rd;
    m4.wr_en      = wr;
    m4.address    = a;
    m4.write_data = wd;
    lows = 0;
    done = 1'b0;
    #1;
    if (!m4.ready) lows = 1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (m4.ready) done = 1'b1;
      else          lows++;
    end
    if (!done) check("access4_timeout", 32'h0, 32'h1);
    rdv = m4.read_data;
    m4.rd_en = 1'b0;
    m4.wr_en = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          hw_idx;  // half-word index written, -1 for reads
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          lows, we_lo, we_hi;
    logic [31:0] rdv;
    string       tag;

    vecs[0] = '{0, 1, 32'd1032, 32'hDEADBEEF, 32'h00000000, 4};
    vecs[1] = '{1, 0, 32'd1032, 32'h0,        32'hDEADBEEF, -1};
    vecs[2] = '{1, 1, 32'd1036, 32'h12345678, 32'hDEADBEEF, 6};
    vecs[3] = '{1, 0, 32'd1036, 32'h0,        32'h12345678, -1};
    vecs[4] = '{0, 1, 32'd1024, 32'h0BADF00D, 32'h12345678, 0};
    vecs[5] = '{0, 1, 32'd1028, 32'hCAFE1234, 32'h12345678, 2};
    vecs[6] = '{1, 0, 32'd1027, 32'h0,        32'h0BADF00D, -1};
    vecs[7] = '{0, 1, 32'd1024 + 32'h80000 + 32'd12, 32'h55AA33CC, 32'h0BADF00D, 6};
    vecs[8] = '{1, 0, 32'd1036, 32'h0,        32'h55AA33CC, -1};

    rst = 1'b0;
    m2.rd_en = 1'b0; m2.wr_en = 1'b0; m2.address = '0; m2.write_data = '0;
    m4.rd_en = 1'b0; m4.wr_en = 1'b0; m4.address = '0; m4.write_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Idle after reset.
    check("reset_ready",     {31'h0, m2.ready}, 32'h1);
    check("reset_strobes",   {29'h0, ce2, oe2, we2}, 32'h7);
    check("reset_dq_drive",  {31'h0, u_dut2.dq_oe}, 32'h0);
    check("reset_read_data", m2.read_data, 32'h0);
    check("reset_sram_addr", 32'(addr2), 32'h0);
    check("reset4_state",    {28'h0, m4.ready, ce4, oe4, we4}, 32'hF);
    check("reset4_read_data", m4.read_data, 32'h0);

    // Directed vector table.
    foreach (vecs[i]) begin
      access2(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lows, we_lo, we_hi, rdv);
      idle2();
      tag = $sformatf("vec%0d", i);
      check({tag, "_ready_low"}, 32'(lows), 32'(1 + 2 * WAIT));
      check({tag, "_read_data"}, rdv, vecs[i].exp_rd);
      if (vecs[i].wr) begin
        check({tag, "_sram_lo"}, {16'h0, sram2[vecs[i].hw_idx]},     {16'h0, vecs[i].wdata[15:0]});
        check({tag, "_sram_hi"}, {16'h0, sram2[vecs[i].hw_idx + 1]}, {16'h0, vecs[i].wdata[31:16]});
        check({tag, "_we_pulses"}, {we_lo[15:0], we_hi[15:0]}, {16'(WAIT - 1), 16'(WAIT - 1)});
        ref_mem[word_of(vecs[i].addr)] = vecs[i].wdata;
      end else begin
        check({tag, "_no_we"}, 32'(we_lo + we_hi), 32'h0);
        ref_rd = vecs[i].exp_rd;
      end
    end

    // Back-to-back reads with rd_en held across both accesses.
    access2(1, 0, 32'd1024, 32'h0, lows, we_lo, we_hi, rdv);
    check("b2b_first_data", rdv, 32'h0BADF00D);
    check("b2b_first_len",  32'(lows), 32'(1 + 2 * WAIT));
    access2(1, 0, 32'd1028, 32'h0, lows, we_lo, we_hi, rdv);
    check("b2b_second_data", rdv, 32'hCAFE1234);
    check("b2b_second_len",  32'(lows), 32'(1 + 2 * WAIT));
    idle2();
    ref_rd = 32'hCAFE1234;

    // Reset during the HIGH phase of a read of word 0.
    m2.rd_en   = 1'b1;
    m2.address = 32'd1024;
    repeat (1 + WAIT) @(negedge clk);
    check("abort_in_high", {30'h0, ce2, addr2[0]}, 32'h1);
    #2;
    rst      = 1'b0;
    m2.rd_en = 1'b0;
    #1;
    check("abort_read_data", m2.read_data, 32'h0);
    check("abort_strobes",   {28'h0, m2.ready, ce2, oe2, we2}, 32'hF);
    check("abort_dq_drive",  {31'h0, u_dut2.dq_oe}, 32'h0);
    check("abort_sram_addr", 32'(addr2), 32'h0);
    @(negedge clk);
    rst    = 1'b1;
    ref_rd = 32'h0;
    @(negedge clk);
    access2(1, 0, 32'd1028, 32'h0, lows, we_lo, we_hi, rdv);
    idle2();
    check("after_abort_data", rdv, 32'hCAFE1234);
    check("after_abort_len",  32'(lows), 32'(1 + 2 * WAIT));
    ref_rd = 32'hCAFE1234;

    // WAIT_CYCLES=4 build: longer freeze, and a wrapped address hits half-words 0/1.
    access4(0, 1, 32'd1024 + 32'h80000, 32'h13579BDF, lows, rdv);
    check("w4_write_len", 32'(lows), 32'd9);
    check("w4_wrap_lo", {16'h0, sram4[0]}, 32'h00009BDF);
    check("w4_wrap_hi", {16'h0, sram4[1]}, 32'h00001357);
    access4(1, 0, 32'd1024, 32'h0, lows, rdv);
    check("w4_read_len",  32'(lows), 32'd9);
    check("w4_read_data", rdv, 32'h13579BDF);

    // Randomized accesses against the word-level model.
    for (int n = 0; n < 60; n++) begin
      bit          r, w;
      int          op, wd_idx;
      logic [31:0] a, d, exp;
      op     = int'($urandom_range(0, 2));
      r      = (op != 1);
      w      = (op != 0);
      wd_idx = int'($urandom_range(0, 15));
      a      = BASE + 32'(4 * wd_idx) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a += 32'h80000;
      d = $urandom;
      access2(r, w, a, d, lows, we_lo, we_hi, rdv);
      if (w) ref_mem[word_of(a)] = d;
      else   ref_rd = ref_read(word_of(a));
      exp = ref_rd;
      check($sformatf("rand%0d_data", n), rdv, exp);
      check($sformatf("rand%0d_len", n), 32'(lows), 32'(1 + 2 * WAIT));
      if ($urandom_range(0, 1) == 1) idle2();
    end
    idle2();

    // Final sweep of the model against SRAM contents for the random word range.
    for (int k = 0; k < 16; k++) begin
      check($sformatf("mem_word%0d", k), {sram2[2*k+1], sram2[2*k]}, ref_read(k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
